// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic MIPS operations into 32-bit words and streams
// them into instruction memory through a sequential write pointer.
module instr_encoder #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned BASE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [25:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam int unsigned       CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                err_q, err_d;

  logic                accept_c;
  logic [31:0]         enc_word_c;
  logic                enc_ok_c;

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_type(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  // Mnemonic-to-word encoder; table-forced zero fields override the inputs.
  always_comb begin
    enc_word_c = 32'h0;
    enc_ok_c   = 1'b1;
    unique case (in_mnem)
      5'd0:    enc_word_c = r_type(in_rs, in_rt, in_rd, 6'h21);
      5'd1:    enc_word_c = r_type(in_rs, in_rt, in_rd, 6'h23);
      5'd2:    enc_word_c = r_type(in_rs, in_rt, in_rd, 6'h24);
      5'd3:    enc_word_c = r_type(in_rs, in_rt, in_rd, 6'h25);
      5'd4:    enc_word_c = r_type(in_rs, in_rt, in_rd, 6'h2B);
      5'd5:    enc_word_c = r_type(in_rs, in_rt, 5'd0, 6'h19);
      5'd6:    enc_word_c = r_type(in_rs, in_rt, 5'd0, 6'h1B);
      5'd7:    enc_word_c = r_type(5'd0, 5'd0, in_rd, 6'h10);
      5'd8:    enc_word_c = r_type(5'd0, 5'd0, in_rd, 6'h12);
      5'd9:    enc_word_c = r_type(in_rs, 5'd0, 5'd0, 6'h08);
      5'd10:   enc_word_c = i_type(6'h23, in_rs, in_rt, in_imm[15:0]);
      5'd11:   enc_word_c = i_type(6'h2B, in_rs, in_rt, in_imm[15:0]);
      5'd12:   enc_word_c = i_type(6'h04, in_rs, in_rt, in_imm[15:0]);
      5'd13:   enc_word_c = i_type(6'h09, in_rs, in_rt, in_imm[15:0]);
      5'd14:   enc_word_c = i_type(6'h0F, 5'd0, in_rt, in_imm[15:0]);
      5'd15:   enc_word_c = i_type(6'h0D, in_rs, in_rt, in_imm[15:0]);
      5'd16:   enc_word_c = i_type(6'h01, in_rs, 5'd0, in_imm[15:0]);
      5'd17:   enc_word_c = j_type(6'h02, in_imm);
      5'd18:   enc_word_c = j_type(6'h03, in_imm);
      default: enc_ok_c   = 1'b0;
    endcase
  end

  // Handshake and output views; a pending write is suppressed while clear is high.
  assign mem_we    = mem_we_q & ~clear;
  assign in_ready  = (state_q != S_FULL) & ~clear & ~((count_q == LAST_C) & mem_we);
  assign accept_c  = in_valid & in_ready;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign full      = (count_q == DEPTH_C);
  assign err       = err_q;

  // Next-state: FSM, write strobe/data, pointer, counter and sticky error.
  always_comb begin
    state_d     = state_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    count_d     = count_q;
    err_d       = err_q;

    if (clear) begin
      state_d    = S_IDLE;
      mem_addr_d = BASE_C;
      count_d    = '0;
      err_d      = 1'b0;
    end else begin
      // Completed write: bump the count; the pointer holds on the final slot.
      if (mem_we_q) begin
        count_d = count_q + CNT_W'(1);
        if (count_q != LAST_C) begin
          mem_addr_d = mem_addr_q + ADDR_W'(1);
        end
      end

      if (accept_c) begin
        if (enc_ok_c) begin
          mem_we_d    = 1'b1;
          mem_wdata_d = enc_word_c;
        end else begin
          err_d = 1'b1;
        end
      end

      unique case (state_q)
        S_IDLE:  if (accept_c) state_d = S_WRITE;
        S_WRITE: if (!accept_c) state_d = S_IDLE;
        S_FULL:  state_d = S_FULL;
        default: state_d = S_IDLE;
      endcase

      if (mem_we_q && (count_q == LAST_C)) begin
        state_d = S_FULL;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_C;
      mem_wdata_q <= 32'h0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding table plus handshake corner cases.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, clear, in_valid, in_valid4;
  logic [4:0]  in_mnem, in_rs, in_rt, in_rd;
  logic [25:0] in_imm;

  logic        in_ready, mem_we, full, err;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [6:0]  count;

  logic        in_ready4, mem_we4, full4, err4;
  logic [1:0]  mem_addr4;
  logic [31:0] mem_wdata4;
  logic [2:0]  count4;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .full(full), .err(err)
  );

  instr_encoder #(.ADDR_W(2), .DEPTH(4), .BASE(0)) dut4 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .count(count4), .full(full4), .err(err4)
  );

  typedef struct {
    logic [4:0]  m;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [25:0] imm;
    logic [31:0] w;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic set_req(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [25:0] imm);
    in_mnem  = m;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_imm   = imm;
    in_valid = 1'b1;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int nw;

    tbl[0]  = '{5'd0,  5'd1,  5'd2,  5'd3,  26'h0,       32'h00221821};
    tbl[1]  = '{5'd1,  5'd4,  5'd5,  5'd6,  26'h0,       32'h00853023};
    tbl[2]  = '{5'd2,  5'd7,  5'd8,  5'd9,  26'h0,       32'h00E84824};
    tbl[3]  = '{5'd3,  5'd31, 5'd0,  5'd17, 26'h0,       32'h03E08825};
    tbl[4]  = '{5'd4,  5'd2,  5'd3,  5'd4,  26'h0,       32'h0043202B};
    tbl[5]  = '{5'd5,  5'd9,  5'd10, 5'd11, 26'h0,       32'h012A0019};
    tbl[6]  = '{5'd6,  5'd1,  5'd1,  5'd5,  26'h0,       32'h0021001B};
    tbl[7]  = '{5'd8,  5'd3,  5'd4,  5'd12, 26'h0,       32'h00006012};
    tbl[8]  = '{5'd9,  5'd31, 5'd5,  5'd6,  26'h0,       32'h03E00008};
    tbl[9]  = '{5'd11, 5'd29, 5'd31, 5'd0,  26'h3FFFF,   32'hAFBFFFFF};
    tbl[10] = '{5'd12, 5'd1,  5'd2,  5'd0,  26'hFFFE,    32'h1022FFFE};
    tbl[11] = '{5'd13, 5'd0,  5'd8,  5'd0,  26'h8000,    32'h24088000};
    tbl[12] = '{5'd15, 5'd2,  5'd3,  5'd0,  26'h00FF,    32'h344300FF};
    tbl[13] = '{5'd16, 5'd4,  5'd7,  5'd0,  26'h0010,    32'h04800010};
    tbl[14] = '{5'd17, 5'd0,  5'd0,  5'd0,  26'h3FFFFFF, 32'h0BFFFFFF};
    tbl[15] = '{5'd18, 5'd0,  5'd0,  5'd0,  26'h0100000, 32'h0C100000};
    tbl[16] = '{5'd7,  5'd5,  5'd6,  5'd2,  26'h0,       32'h00001010};

    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0;
    in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we",    32'(mem_we),   32'd0);
    chk("rst_addr",  32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata,     32'd0);
    chk("rst_count", 32'(count),    32'd0);
    chk("rst_full",  32'(full),     32'd0);
    chk("rst_err",   32'(err),      32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Encoding table, one isolated request per vector.
    for (int i = 0; i < NV; i++) begin
      set_req(tbl[i].m, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].imm);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_we", i),    32'(mem_we),   32'd1);
      chk($sformatf("v%0d_addr", i),  32'(mem_addr), 32'(i));
      chk($sformatf("v%0d_wdata", i), mem_wdata,     tbl[i].w);
      tick();
      @(negedge clk);
      chk($sformatf("v%0d_count", i), 32'(count),  32'(i + 1));
      chk($sformatf("v%0d_idle", i),  32'(mem_we), 32'd0);
      tick();
    end

    // Clear returns pointer and count to base.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    @(negedge clk);
    chk("clr_count", 32'(count),    32'd0);
    chk("clr_addr",  32'(mem_addr), 32'd0);
    tick();

    // Back-to-back LW then LUI, no bubble.
    set_req(5'd10, 5'd29, 5'd8, 5'd0, 26'h0004);
    tick();
    set_req(5'd14, 5'd7, 5'd1, 5'd0, 26'h1234);
    @(negedge clk);
    chk("b2b0_we",    32'(mem_we),   32'd1);
    chk("b2b0_addr",  32'(mem_addr), 32'd0);
    chk("b2b0_wdata", mem_wdata,     32'h8FA80004);
    chk("b2b0_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b1_we",    32'(mem_we),   32'd1);
    chk("b2b1_addr",  32'(mem_addr), 32'd1);
    chk("b2b1_wdata", mem_wdata,     32'h3C011234);
    chk("b2b1_count", 32'(count),    32'd1);
    tick();
    @(negedge clk);
    chk("b2b_count", 32'(count),  32'd2);
    chk("b2b_hold",  mem_wdata,   32'h3C011234);
    tick();

    // Unsupported mnemonic consumed, sets err, no write.
    set_req(5'd25, 5'd1, 5'd2, 5'd3, 26'h0);
    @(negedge clk);
    chk("bad_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bad_err", 32'(err),    32'd1);
    chk("bad_we",  32'(mem_we), 32'd0);
    tick();
    @(negedge clk);
    chk("bad_count", 32'(count),    32'd2);
    chk("bad_addr",  32'(mem_addr), 32'd2);
    tick();
    set_req(5'd13, 5'd1, 5'd2, 5'd0, 26'h0005);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("addiu_we",    32'(mem_we),   32'd1);
    chk("addiu_addr",  32'(mem_addr), 32'd2);
    chk("addiu_wdata", mem_wdata,     32'h24220005);
    tick();
    @(negedge clk);
    chk("addiu_count", 32'(count), 32'd3);
    chk("err_sticky",  32'(err),   32'd1);
    tick();

    // Clear in the write cycle drops the write and blocks a concurrent request.
    set_req(5'd0, 5'd1, 5'd2, 5'd3, 26'h0);
    tick();
    clear = 1'b1;
    @(negedge clk);
    chk("clrw_we",    32'(mem_we),   32'd0);
    chk("clrw_ready", 32'(in_ready), 32'd0);
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("clrw_we2",   32'(mem_we),   32'd0);
    chk("clrw_count", 32'(count),    32'd0);
    chk("clrw_addr",  32'(mem_addr), 32'd0);
    chk("clrw_err",   32'(err),      32'd0);
    tick();

    // Asynchronous reset mid-stream aborts the strobe immediately.
    set_req(5'd0, 5'd1, 5'd2, 5'd3, 26'h0);
    tick();
    set_req(5'd1, 5'd4, 5'd5, 5'd6, 26'h0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_we",    32'(mem_we), 32'd1);
    chk("pre_rst_count", 32'(count),  32'd1);
    reset = 1'b0;
    #1;
    chk("arst_we",    32'(mem_we),   32'd0);
    chk("arst_count", 32'(count),    32'd0);
    chk("arst_addr",  32'(mem_addr), 32'd0);
    chk("arst_wdata", mem_wdata,     32'd0);
    tick();
    reset = 1'b1;
    tick();

    // DEPTH=4 instance: valid held, exactly four accepts and writes.
    set_req(5'd0, 5'd1, 5'd2, 5'd3, 26'h0);
    in_valid  = 1'b0;
    in_valid4 = 1'b1;
    acc = 0;
    nw  = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (in_valid4 && in_ready4) acc++;
      if (mem_we4) begin
        chk($sformatf("d4_addr%0d", nw), 32'(mem_addr4), 32'(nw % 4));
        nw++;
      end
      tick();
    end
    chk("d4_accepts", 32'(acc), 32'd4);
    chk("d4_writes",  32'(nw),  32'd4);
    @(negedge clk);
    chk("d4_full",  32'(full4),     32'd1);
    chk("d4_ready", 32'(in_ready4), 32'd0);
    chk("d4_count", 32'(count4),    32'd4);
    chk("d4_we",    32'(mem_we4),   32'd0);
    tick();
    in_valid4 = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    @(negedge clk);
    chk("d4_clr_full",  32'(full4),     32'd0);
    chk("d4_clr_count", 32'(count4),    32'd0);
    chk("d4_clr_ready", 32'(in_ready4), 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
